// File: rtl/aes_block_collector.sv
// Collects the 16-byte result stream that follows the engine's z_ready pulse
// into a 128-bit mode-tagged block and queues it for a valid/ready consumer.
module aes_block_collector #(
    parameter int FIRST_BYTE_DELAY = 0,
    parameter int DEPTH            = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             z_i,
    input  logic                   z_ready_i,
    input  logic                   mode_i,
    input  logic                   clr_flags_i,
    output logic [127:0]           blk_data_o,
    output logic                   blk_mode_o,
    output logic                   blk_valid_o,
    input  logic                   blk_ready_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic                   proto_err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [3:0]    DLY_LOAD = (FIRST_BYTE_DELAY > 0) ? 4'(FIRST_BYTE_DELAY - 1) : 4'd0;
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2
    } state_e;

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic [3:0]     dly_q;
    logic           mode_q;
    logic           busy_q;
    logic [119:0]   asm_q;

    logic [127:0]   mem_data_q [DEPTH];
    logic           mem_mode_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic [LW-1:0]  level_d;
    logic           valid_q;
    logic           overflow_q;
    logic           proto_err_q;

    logic           push_s;
    logic           pop_s;
    logic           push_ok_s;
    logic           ovf_set_s;
    logic           perr_set_s;

    // Byte 15 is taken straight from z_i so the full word is pushed on its capture edge.
    assign push_s     = (state_q == ST_COLLECT) && (cnt_q == 4'd15);
    assign pop_s      = valid_q && blk_ready_i;
    assign push_ok_s  = push_s && ((level_q < LVL_FULL) || pop_s);
    assign ovf_set_s  = push_s && !push_ok_s;
    assign perr_set_s = z_ready_i && (state_q != ST_IDLE);

    // Framing FSM: start detection, first-byte delay and byte assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            dly_q   <= 4'd0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            asm_q   <= 120'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (z_ready_i) begin
                        mode_q <= mode_i;
                        busy_q <= 1'b1;
                        if (FIRST_BYTE_DELAY == 0) begin
                            asm_q   <= {asm_q[111:0], z_i};
                            cnt_q   <= 4'd1;
                            state_q <= ST_COLLECT;
                        end else begin
                            dly_q   <= DLY_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dly_q == 4'd0) begin
                        asm_q   <= {asm_q[111:0], z_i};
                        cnt_q   <= 4'd1;
                        state_q <= ST_COLLECT;
                    end else begin
                        dly_q <= dly_q - 4'd1;
                    end
                end
                ST_COLLECT: begin
                    if (cnt_q == 4'd15) begin
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        asm_q <= {asm_q[111:0], z_i};
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy next-state; simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        if (push_ok_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_s && !push_ok_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Block FIFO storage, pointers and registered valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_data_q[k] <= 128'd0;
                mem_mode_q[k] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_data_q[wr_ptr_q] <= {asm_q, z_i};
                mem_mode_q[wr_ptr_q] <= mode_q;
                wr_ptr_q             <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
            valid_q <= (level_d != '0);
        end
    end

    // Sticky status flags; a set on the clearing edge takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            overflow_q  <= ovf_set_s  | (overflow_q  & ~clr_flags_i);
            proto_err_q <= perr_set_s | (proto_err_q & ~clr_flags_i);
        end
    end

    assign blk_data_o  = mem_data_q[rd_ptr_q];
    assign blk_mode_o  = mem_mode_q[rd_ptr_q];
    assign blk_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_aes_block_collector.sv
// Bench for aes_block_collector: two instances (first-byte delay 0 and 3) share
// stimulus and are compared every cycle against a timestamp-based block model.
module tb_aes_block_collector;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    z;
    logic          zr;
    logic          md;
    logic          clr;
    logic          rdy;

    logic [127:0]  d_data  [2];
    logic          d_mode  [2];
    logic          d_valid [2];
    logic          d_busy  [2];
    logic          d_ovf   [2];
    logic          d_perr  [2];
    logic [LW-1:0] d_level [2];

    aes_block_collector #(.FIRST_BYTE_DELAY(0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .z_i(z), .z_ready_i(zr), .mode_i(md), .clr_flags_i(clr),
        .blk_data_o(d_data[0]), .blk_mode_o(d_mode[0]), .blk_valid_o(d_valid[0]),
        .blk_ready_i(rdy), .busy_o(d_busy[0]), .level_o(d_level[0]),
        .overflow_o(d_ovf[0]), .proto_err_o(d_perr[0]));

    aes_block_collector #(.FIRST_BYTE_DELAY(3), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst), .z_i(z), .z_ready_i(zr), .mode_i(md), .clr_flags_i(clr),
        .blk_data_o(d_data[1]), .blk_mode_o(d_mode[1]), .blk_valid_o(d_valid[1]),
        .blk_ready_i(rdy), .busy_o(d_busy[1]), .level_o(d_level[1]),
        .overflow_o(d_ovf[1]), .proto_err_o(d_perr[1]));

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a block is the 16 bytes seen at edges start+D .. start+D+15.
    int           ecyc;
    bit           m_act   [2];
    int           m_start [2];
    logic         m_md    [2];
    logic [127:0] m_buf   [2];
    logic [128:0] m_fifo  [2][DEPTH];
    int           m_cnt   [2];
    bit           m_ovf   [2];
    bit           m_perr  [2];

    function automatic int dly_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic [127:0] mk(input logic [3:0] id);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = {id, k[3:0]};
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d at t=%0t got %h want %h", nm, i, $time, a, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_cnt[i]  = 0;
            m_ovf[i]  = 1'b0;
            m_perr[i] = 1'b0;
            for (int k = 0; k < DEPTH; k++) m_fifo[i][k] = '0;
        end
    endtask

    task automatic model_step();
        bit was_act, pop, push, push_ok, set_o, set_p;
        int off;
        ecyc++;
        for (int i = 0; i < 2; i++) begin
            was_act = m_act[i];
            pop     = (m_cnt[i] > 0) && rdy;
            push    = 1'b0;
            set_p   = was_act && zr;
            if (!was_act && zr) begin
                m_act[i]   = 1'b1;
                m_start[i] = ecyc;
                m_md[i]    = md;
            end
            if (m_act[i] && (ecyc - m_start[i] >= dly_of(i))) begin
                off = ecyc - m_start[i] - dly_of(i);
                m_buf[i][127-8*off -: 8] = z;
                if (off == 15) begin
                    push     = 1'b1;
                    m_act[i] = 1'b0;
                end
            end
            push_ok = push && ((m_cnt[i] < DEPTH) || pop);
            set_o   = push && !push_ok;
            if (pop) begin
                for (int k = 0; k < DEPTH - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
                m_cnt[i]--;
            end
            if (push_ok) begin
                m_fifo[i][m_cnt[i]] = {m_md[i], m_buf[i]};
                m_cnt[i]++;
            end
            m_ovf[i]  = set_o || (m_ovf[i]  && !clr);
            m_perr[i] = set_p || (m_perr[i] && !clr);
        end
    endtask

    task automatic cyc(input bit zr_v, input logic [7:0] z_v, input bit md_v, input bit rdy_v, input bit clr_v);
        zr = zr_v; z = z_v; md = md_v; rdy = rdy_v; clr = clr_v;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_step();
    endtask

    task automatic send_word(input logic [127:0] w, input bit md_v, input bit rdy_v, input bit rdy_last, input int zr_at);
        for (int k = 0; k < 16; k++)
            cyc((k == 0) || (k == zr_at), w[127-8*k -: 8], md_v, (k == 15) ? rdy_last : rdy_v, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy_v, input bit clr_v);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, rdy_v, clr_v);
    endtask

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("valid", i, 128'(d_valid[i]), 128'(m_cnt[i] > 0));
            chk("level", i, 128'(d_level[i]), 128'(m_cnt[i]));
            chk("busy",  i, 128'(d_busy[i]),  128'(m_act[i]));
            chk("ovf",   i, 128'(d_ovf[i]),   128'(m_ovf[i]));
            chk("perr",  i, 128'(d_perr[i]),  128'(m_perr[i]));
            if (m_cnt[i] > 0) begin
                chk("data", i, d_data[i], m_fifo[i][0][127:0]);
                chk("mode", i, 128'(d_mode[i]), 128'(m_fifo[i][0][128]));
            end else if (rst) begin
                chk("rst_data", i, d_data[i], 128'd0);
                chk("rst_mode", i, 128'(d_mode[i]), 128'd0);
            end
        end
    end

    initial begin
        logic [127:0] pat;
        ecyc = 0;
        rst = 1'b1; zr = 1'b0; z = 8'h00; md = 1'b0; rdy = 1'b0; clr = 1'b0;
        model_reset();
        idle(3, 1'b0, 1'b0);
        chk("lit_rst_valid", 0, 128'(d_valid[0]), 128'd0);
        chk("lit_rst_level", 0, 128'(d_level[0]), 128'd0);
        rst = 1'b0;
        idle(2, 1'b0, 1'b0);

        // Known-answer block, delay 0.
        pat = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        send_word(pat, 1'b0, 1'b0, 1'b0, -1);
        chk("lit_t1_valid", 0, 128'(d_valid[0]), 128'd1);
        chk("lit_t1_data",  0, d_data[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("lit_t1_mode",  0, 128'(d_mode[0]), 128'd0);
        chk("lit_t1_level", 0, 128'(d_level[0]), 128'd1);
        chk("lit_t1_busy",  0, 128'(d_busy[0]), 128'd0);
        idle(8, 1'b1, 1'b1);

        // Three blocks into a two-deep FIFO with no consumer.
        send_word(mk(4'd1), 1'b1, 1'b0, 1'b0, -1); idle(4, 1'b0, 1'b0);
        send_word(mk(4'd2), 1'b1, 1'b0, 1'b0, -1); idle(4, 1'b0, 1'b0);
        send_word(mk(4'd3), 1'b1, 1'b0, 1'b0, -1); idle(4, 1'b0, 1'b0);
        chk("lit_t2_level", 0, 128'(d_level[0]), 128'd2);
        chk("lit_t2_ovf",   0, 128'(d_ovf[0]), 128'd1);
        chk("lit_t2_head",  0, 128'(d_data[0][127:120]), 128'h10);
        chk("lit_t2_mode",  0, 128'(d_mode[0]), 128'd1);
        idle(1, 1'b0, 1'b1);
        chk("lit_t2_clr",   0, 128'(d_ovf[0]), 128'd0);

        // Full FIFO, pop on the same edge as the push.
        send_word(mk(4'd4), 1'b1, 1'b0, 1'b1, -1);
        chk("lit_t3_level", 0, 128'(d_level[0]), 128'd2);
        chk("lit_t3_ovf",   0, 128'(d_ovf[0]), 128'd0);
        chk("lit_t3_head2", 0, 128'(d_data[0][127:120]), 128'h20);
        idle(1, 1'b1, 1'b0);
        chk("lit_t3_head4", 0, 128'(d_data[0][127:120]), 128'h40);
        idle(8, 1'b1, 1'b1);

        // Delay-3 instance must skip the junk bytes.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) cyc(1'b0, 8'(k), 1'b0, 1'b0, 1'b0);
        chk("lit_t4_valid", 1, 128'(d_valid[1]), 128'd1);
        chk("lit_t4_data",  1, d_data[1], 128'h000102030405060708090a0b0c0d0e0f);
        idle(8, 1'b1, 1'b1);

        // Restart attempt mid-block, then reset mid-block.
        send_word(mk(4'd5), 1'b0, 1'b0, 1'b0, 7);
        chk("lit_t5_perr", 0, 128'(d_perr[0]), 128'd1);
        chk("lit_t5_data", 0, d_data[0], 128'h505152535455565758595a5b5c5d5e5f);
        idle(8, 1'b1, 1'b1);
        pat = mk(4'd6);
        for (int k = 0; k < 9; k++) cyc(k == 0, pat[127-8*k -: 8], 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("lit_t5_rlevel", 0, 128'(d_level[0]), 128'd0);
        chk("lit_t5_rvalid", 0, 128'(d_valid[0]), 128'd0);
        chk("lit_t5_rbusy",  0, 128'(d_busy[0]), 128'd0);
        idle(2, 1'b0, 1'b0);
        rst = 1'b0;
        idle(12, 1'b0, 1'b0);
        chk("lit_t5_noblk", 0, 128'(d_valid[0]), 128'd0);

        // Back-to-back results with a ready consumer.
        idle(1, 1'b1, 1'b1);
        send_word(mk(4'd7), 1'b0, 1'b1, 1'b1, -1);
        chk("lit_t6_head7", 0, 128'(d_data[0][127:120]), 128'h70);
        send_word(mk(4'd8), 1'b1, 1'b1, 1'b1, -1);
        chk("lit_t6_head8", 0, 128'(d_data[0][127:120]), 128'h80);
        chk("lit_t6_mode8", 0, 128'(d_mode[0]), 128'd1);
        chk("lit_t6_perr",  0, 128'(d_perr[0]), 128'd0);
        idle(6, 1'b1, 1'b1);

        // Random traffic with varying consumer pressure.
        for (int seg = 0; seg < 6; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 95);
            for (int n = 0; n < 500; n++) begin
                if ($urandom_range(0, 999) == 0) begin
                    rst = 1'b1;
                    model_reset();
                    idle(2, 1'b0, 1'b0);
                    rst = 1'b0;
                end
                cyc($urandom_range(0, 19) == 0, 8'($urandom), 1'($urandom),
                    $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 39) == 0);
            end
        end
        idle(4, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_block_collector.md
Name: aes_block_collector

Overview:
Downstream stage of the byte-serial AES encrypt/decrypt engine. It captures the 16-byte result stream that follows the engine's z_ready pulse and assembles it into a 128-bit block, tagged with the mode (encrypt/decrypt) it was produced under. Completed blocks go into a small FIFO and are presented on a valid/ready interface to the consumer (host bus or UART packer).

Parameters:
FIRST_BYTE_DELAY, 0, cycles between the clock edge that samples z_ready=1 and the edge that samples byte 0 (range 0..15)
DEPTH, 2, output FIFO depth in blocks (power of 2, at least 2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
z  input  8  result byte from engine
z_ready  input  1  one-cycle pulse from engine marking start of a 16-byte result
mode  input  1  engine mode; sampled with z_ready (0 = encrypt, 1 = decrypt)
clr_flags  input  1  synchronous clear of overflow and proto_err
blk_data  output  128  assembled block; byte 0 in [127:120], byte 15 in [7:0]
blk_mode  output  1  mode tag of the head block
blk_valid  output  1  head FIFO entry is valid
blk_ready  input  1  consumer accepts head block when blk_valid && blk_ready
busy  output  1  in WAIT or COLLECT
level  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky: a completed block was dropped because the FIFO was full
proto_err  output  1  sticky: z_ready seen while busy

Behaviour:
- Reset values (async): state=IDLE; byte counter=0; delay counter=0; FIFO empty; blk_valid=0; blk_data=0; blk_mode=0; busy=0; level=0; overflow=0; proto_err=0.
- States: IDLE, WAIT, COLLECT.
- IDLE:
  - On z_ready=1, latch mode.
  - If FIRST_BYTE_DELAY=0, capture z as byte 0 on the same edge and go to COLLECT with count=1.
  - Otherwise load the delay counter with FIRST_BYTE_DELAY-1 and go to WAIT.
- WAIT: decrement each cycle. The edge on which the counter is 0 captures byte 0 and moves to COLLECT with count=1.
- COLLECT:
  - Each edge captures z into byte slot[count]; count increments.
  - The edge that captures byte 15 also performs the FIFO push of {mode, 128-bit word} and returns to IDLE.
  - Bytes are captured on consecutive cycles; there are no gaps.
- z_ready=1 while in WAIT or COLLECT is ignored for framing: the current block continues and proto_err is set.
- z_ready on the same edge that captures byte 15 is also a proto_err, and is not treated as a new start.
- busy = (state != IDLE).
- FIFO:
  - Push is accepted when level<DEPTH, or when a pop (blk_valid && blk_ready) happens on the same edge.
  - Otherwise the block is discarded and overflow is set.
  - Pop and push on the same edge leave level unchanged.
  - Pointers wrap modulo DEPTH.
- Output timing:
  - Latency from the edge capturing byte 15 into an empty FIFO to blk_valid=1 is 1 cycle: blk_valid is registered and visible after that edge.
  - blk_data and blk_mode are driven from the head entry and hold stable while blk_valid && !blk_ready.
- Sticky flags: overflow and proto_err stay set until clr_flags=1. If set and clear happen on the same edge, set wins.
- Reset mid-operation: a partial block is discarded; no push occurs.
- The engine guarantees at least 179 cycles between z_ready pulses. The collector must not depend on this; back-to-back starts are accepted from IDLE the cycle after the return from COLLECT.

Test Plan:
1. FIRST_BYTE_DELAY=0, mode=0. Pulse z_ready with z=69 and drive bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a on consecutive cycles -> one cycle after byte 15: blk_valid=1, blk_data=69c4e0d86a7b0430d8cdb78070b4c55a, blk_mode=0, level=1, busy=0.
2. Hold blk_ready=0 and stream three blocks (mode=1) with DEPTH=2 -> level reaches 2, third block dropped, overflow=1. blk_data holds block 1 stable. After clr_flags, overflow=0.
3. With DEPTH=2 and level=2, assert blk_ready=1 on the edge that captures byte 15 of the third block -> push accepted, level stays 2, overflow=0. Heads appear in order 2, then 3.
4. FIRST_BYTE_DELAY=3. Pulse z_ready, drive junk bytes AA for 3 cycles, then 00 01 .. 0f -> blk_data=000102030405060708090a0b0c0d0e0f with no AA byte captured.
5. Pulse z_ready again at byte 7 of a block -> proto_err=1 and the block completes unchanged at 16 bytes. Separately, assert rst at byte 9 -> level=0, blk_valid=0, busy=0, and no block is emitted.
6. Feed two results back-to-back (second z_ready on the cycle after byte 15) with blk_ready=1 -> two blocks delivered in order, proto_err=0.
